// File: rtl/lc3_dmem_responder.sv
// rtl/lc3_dmem_responder.sv - LC3 data-memory responder with wait states and one-cycle completion strobe.
// Optional address bounds checking is compiled in with LC3_DMEM_BOUNDS_CHECK_EN.
module lc3_dmem_responder #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              data_req,
    input  logic              Data_rd,
    input  logic [ADDR_W-1:0] Data_addr,
    input  logic [DATA_W-1:0] Data_din,
    output logic [DATA_W-1:0] Data_dout,
    output logic              complete_data,
    output logic              dmem_busy,
    output logic              dmem_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [3:0]        cnt;
    logic [3:0]        next_cnt;

    logic              rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              err_q;

    logic              accept;
    logic              enter_resp;
    logic              eff_rd;
    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] eff_din;
    logic [IDX_W-1:0]  eff_idx;
    logic              eff_oob;

    logic [DATA_W-1:0] mem [DEPTH];

    assign accept = (state == IDLE) && data_req;

    // With zero latency the response is committed on the accept edge, so the
    // live request fields are used there; otherwise the latched copies are.
    assign eff_rd   = (state == IDLE) ? Data_rd   : rd_q;
    assign eff_addr = (state == IDLE) ? Data_addr : addr_q;
    assign eff_din  = (state == IDLE) ? Data_din  : din_q;
    assign eff_idx  = eff_addr[IDX_W-1:0];

`ifdef LC3_DMEM_BOUNDS_CHECK_EN
    assign eff_oob = ({1'b0, eff_addr} >= (ADDR_W+1)'(DEPTH));
`else
    logic addr_hi_unused;
    assign addr_hi_unused = ^eff_addr[ADDR_W-1:IDX_W];
    assign eff_oob        = 1'b0;
`endif

    assign enter_resp = (next_state == RESP) && (state != RESP);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (data_req) begin
                    if (LATENCY == 0) begin
                        next_state = RESP;
                        next_cnt   = 4'd0;
                    end else begin
                        next_state = WAIT;
                        next_cnt   = 4'(LATENCY);
                    end
                end
            end
            WAIT: begin
                if (!data_req) begin
                    next_state = IDLE;
                    next_cnt   = 4'd0;
                end else if (cnt <= 4'd1) begin
                    next_state = RESP;
                    next_cnt   = 4'd0;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            RESP: begin
                next_state = IDLE;
                next_cnt   = 4'd0;
            end
            default: begin
                next_state = IDLE;
                next_cnt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        complete_data = (state == RESP);
        dmem_busy     = (state != IDLE);
`ifdef LC3_DMEM_BOUNDS_CHECK_EN
        dmem_err      = (state == RESP) && err_q;
`else
        dmem_err      = 1'b0;
`endif
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            rd_q   <= Data_rd;
            addr_q <= Data_addr;
            din_q  <= Data_din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            Data_dout <= '0;
            err_q     <= 1'b0;
        end else if (enter_resp) begin
            err_q <= eff_oob;
            if (eff_rd) begin
                Data_dout <= eff_oob ? DATA_W'(16'hDEAD) : mem[eff_idx];
            end
        end
    end

    // Memory is not cleared by reset; reset only blocks a pending commit.
    always_ff @(posedge clock) begin
        if (!reset && enter_resp && !eff_rd && !eff_oob) begin
            mem[eff_idx] <= eff_din;
        end
    end

endmodule

// File: tb/tb_lc3_dmem_responder.sv
// tb/tb_lc3_dmem_responder.sv - directed bench for lc3_dmem_responder at LATENCY 2, 0 and 3.
module tb_lc3_dmem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        rd_s;
    logic [15:0] addr_s;
    logic [15:0] din_s;
    logic        req  [3];
    logic [15:0] dout [3];
    logic        cd   [3];
    logic        busy [3];
    logic        err  [3];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    // instance 0: LATENCY=2, instance 1: LATENCY=0, instance 2: LATENCY=3
    lc3_dmem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .LATENCY(2)) u_l2 (
        .clock(clock), .reset(reset), .data_req(req[0]), .Data_rd(rd_s),
        .Data_addr(addr_s), .Data_din(din_s), .Data_dout(dout[0]),
        .complete_data(cd[0]), .dmem_busy(busy[0]), .dmem_err(err[0]));

    lc3_dmem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .LATENCY(0)) u_l0 (
        .clock(clock), .reset(reset), .data_req(req[1]), .Data_rd(rd_s),
        .Data_addr(addr_s), .Data_din(din_s), .Data_dout(dout[1]),
        .complete_data(cd[1]), .dmem_busy(busy[1]), .dmem_err(err[1]));

    lc3_dmem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .LATENCY(3)) u_l3 (
        .clock(clock), .reset(reset), .data_req(req[2]), .Data_rd(rd_s),
        .Data_addr(addr_s), .Data_din(din_s), .Data_dout(dout[2]),
        .complete_data(cd[2]), .dmem_busy(busy[2]), .dmem_err(err[2]));

    // Drives one request on instance u and reports when complete_data showed up.
    // lat counts sample points after the accept edge (1 = cycle right after it); -1 = timeout.
    task automatic issue(input int u, input logic rd, input logic [15:0] addr,
                         input logic [15:0] din, output int lat, output int busy_n,
                         output logic [15:0] d, output logic e);
        @(negedge clock);
        rd_s   = rd;
        addr_s = addr;
        din_s  = din;
        req[u] = 1'b1;
        lat    = -1;
        busy_n = 0;
        d      = 16'h0;
        e      = 1'b0;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(negedge clock);
            if (busy[u]) busy_n++;
            if (cd[u]) begin
                lat = n;
                d   = dout[u];
                e   = err[u];
            end
        end
        req[u] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int u = 0; u < 3; u++) req[u] = 1'b0;
        rd_s = 1'b0; addr_s = 16'h0; din_s = 16'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clock);
            for (int u = 0; u < 3; u++) begin
                vectors++;
                if ({dout[u], cd[u], busy[u], err[u]} !== 19'h0) begin
                    miscompares++;
                    $display("FAIL reset_idle inst%0d: dout=%h cd=%b busy=%b err=%b, required all 0",
                             u, dout[u], cd[u], busy[u], err[u]);
                end
            end
        end
    endtask

    task automatic test_write_read_l2();
        int lat, bn;
        logic [15:0] d;
        logic e;
        issue(0, 1'b0, 16'h0010, 16'h1234, lat, bn, d, e);
        vectors++;
        if (lat !== 3) begin miscompares++; $display("FAIL wr_latency: got %0d, required 3", lat); end
        vectors++;
        if (bn !== 3) begin miscompares++; $display("FAIL wr_busy_cycles: got %0d, required 3", bn); end
        vectors++;
        if (d !== 16'h0000) begin miscompares++; $display("FAIL wr_dout_held: got %h, required 0000", d); end
        vectors++;
        if (e !== 1'b0) begin miscompares++; $display("FAIL wr_err: got %b, required 0", e); end
        @(negedge clock);
        vectors++;
        if (cd[0] !== 1'b0 || busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_one_cycle: cd=%b busy=%b, required 0 0", cd[0], busy[0]);
        end
        issue(0, 1'b1, 16'h0010, 16'h0000, lat, bn, d, e);
        vectors++;
        if (lat !== 3) begin miscompares++; $display("FAIL rd_latency: got %0d, required 3", lat); end
        vectors++;
        if (d !== 16'h1234) begin miscompares++; $display("FAIL rd_data: got %h, required 1234", d); end
    endtask

    task automatic test_back_to_back_l0();
        int lat, bn;
        logic [15:0] d;
        logic e;
        logic [7:0] pat;
        issue(1, 1'b0, 16'h0030, 16'hCAFE, lat, bn, d, e);
        vectors++;
        if (lat !== 1) begin miscompares++; $display("FAIL l0_wr_latency: got %0d, required 1", lat); end
        issue(1, 1'b1, 16'h0030, 16'h0000, lat, bn, d, e);
        vectors++;
        if (lat !== 1) begin miscompares++; $display("FAIL l0_rd_latency: got %0d, required 1", lat); end
        vectors++;
        if (d !== 16'hCAFE) begin miscompares++; $display("FAIL l0_rd_data: got %h, required cafe", d); end
        @(negedge clock);
        rd_s = 1'b1; addr_s = 16'h0030; req[1] = 1'b1;
        pat = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            pat[i] = cd[1];
            if (cd[1]) begin
                vectors++;
                if (dout[1] !== 16'hCAFE) begin
                    miscompares++;
                    $display("FAIL b2b_data slot%0d: got %h, required cafe", i, dout[1]);
                end
            end
        end
        req[1] = 1'b0;
        vectors++;
        if (pat !== 8'b0101_0101) begin
            miscompares++;
            $display("FAIL b2b_pattern: got %b, required 01010101", pat);
        end
    endtask

    task automatic test_abort_l3();
        int lat, bn;
        logic [15:0] d;
        logic e;
        logic seen;
        issue(2, 1'b0, 16'h0020, 16'h1111, lat, bn, d, e);
        vectors++;
        if (lat !== 4) begin miscompares++; $display("FAIL l3_wr_latency: got %0d, required 4", lat); end
        @(negedge clock);
        @(negedge clock);
        rd_s = 1'b0; addr_s = 16'h0020; din_s = 16'hBEEF; req[2] = 1'b1;
        @(negedge clock);
        vectors++;
        if (busy[2] !== 1'b1) begin miscompares++; $display("FAIL abort_busy_wait: got %b, required 1", busy[2]); end
        @(negedge clock);
        req[2] = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (cd[2]) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin miscompares++; $display("FAIL abort_no_complete: got %b, required 0", seen); end
        vectors++;
        if (busy[2] !== 1'b0) begin miscompares++; $display("FAIL abort_idle: busy=%b, required 0", busy[2]); end
        issue(2, 1'b1, 16'h0020, 16'h0000, lat, bn, d, e);
        vectors++;
        if (lat !== 4) begin miscompares++; $display("FAIL abort_rd_latency: got %0d, required 4", lat); end
        vectors++;
        if (d !== 16'h1111) begin miscompares++; $display("FAIL abort_rd_data: got %h, required 1111", d); end
    endtask

    task automatic test_reset_mid_wait();
        int lat, bn;
        logic [15:0] d;
        logic e;
        issue(0, 1'b0, 16'h0005, 16'h2222, lat, bn, d, e);
        vectors++;
        if (lat !== 3) begin miscompares++; $display("FAIL pre_wr_latency: got %0d, required 3", lat); end
        @(negedge clock);
        @(negedge clock);
        rd_s = 1'b0; addr_s = 16'h0005; din_s = 16'hAAAA; req[0] = 1'b1;
        @(negedge clock);
        vectors++;
        if (busy[0] !== 1'b1) begin miscompares++; $display("FAIL rst_busy_wait: got %b, required 1", busy[0]); end
        reset = 1'b1;
        @(negedge clock);
        vectors++;
        if (busy[0] !== 1'b0 || cd[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_to_idle: busy=%b cd=%b, required 0 0", busy[0], cd[0]);
        end
        reset = 1'b0;
        req[0] = 1'b0;
        repeat (4) @(negedge clock);
        issue(0, 1'b1, 16'h0005, 16'h0000, lat, bn, d, e);
        vectors++;
        if (d !== 16'h2222) begin miscompares++; $display("FAIL rst_no_commit: got %h, required 2222", d); end
    endtask

    task automatic test_bounds();
        int lat, bn;
        logic [15:0] d;
        logic e;
        logic [15:0] exp_low;
        logic [15:0] exp_high;
        logic        exp_err;
`ifdef LC3_DMEM_BOUNDS_CHECK_EN
        exp_low = 16'h2222; exp_high = 16'hDEAD; exp_err = 1'b1;
`else
        exp_low = 16'h5555; exp_high = 16'h5555; exp_err = 1'b0;
`endif
        issue(0, 1'b0, 16'h0105, 16'h5555, lat, bn, d, e);
        vectors++;
        if (lat !== 3) begin miscompares++; $display("FAIL oob_wr_latency: got %0d, required 3", lat); end
        vectors++;
        if (e !== exp_err) begin miscompares++; $display("FAIL oob_wr_err: got %b, required %b", e, exp_err); end
        @(negedge clock);
        vectors++;
        if (err[0] !== 1'b0) begin miscompares++; $display("FAIL oob_err_one_cycle: got %b, required 0", err[0]); end
        issue(0, 1'b1, 16'h0005, 16'h0000, lat, bn, d, e);
        vectors++;
        if (d !== exp_low) begin miscompares++; $display("FAIL oob_mem05: got %h, required %h", d, exp_low); end
        vectors++;
        if (e !== 1'b0) begin miscompares++; $display("FAIL inrange_err: got %b, required 0", e); end
        issue(0, 1'b1, 16'h0105, 16'h0000, lat, bn, d, e);
        vectors++;
        if (d !== exp_high) begin miscompares++; $display("FAIL oob_rd_data: got %h, required %h", d, exp_high); end
        vectors++;
        if (e !== exp_err) begin miscompares++; $display("FAIL oob_rd_err: got %b, required %b", e, exp_err); end
    endtask

    initial begin
        test_reset();
        test_write_read_l2();
        test_back_to_back_l0();
        test_abort_l3();
        test_reset_mid_wait();
        test_bounds();
        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
